// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes and FSM state encoding.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_XFER = 3'd3,
        WR_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/axil_wait_timer.sv
// Watchdog for a single AXI wait phase; sets a sticky flag when the wait reaches the limit.
module axil_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic timeout_err
);
    localparam int RAW_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = (RAW_W < 8) ? 8 : ((RAW_W > 16) ? 16 : RAW_W);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Count saturates at the limit so a long stall cannot wrap around.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!run || clear) begin
                count <= '0;
            end else if (count != LIMIT) begin
                count <= count + 1'b1;
            end
            if (run && count == LIMIT) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_lite_master.sv
// Single-outstanding AXI4-Lite master bridging a request/response port to AR/R and AW/W/B.
// Optional watchdog (timeout_err port) enabled by defining AXIL_LITE_MASTER_TIMEOUT_EN.
module axil_lite_master
    import axil_pkg::*;
#(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [AXIL_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] req_wstrb,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_write,
    output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic                         arvalid,
    output logic [AXIL_ADDR_WIDTH-1:0]   araddr,
    output logic                         rready,
    input  logic                         arready,
    input  logic                         rvalid,
    input  logic [AXIL_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                   rresp,
    output logic                         awvalid,
    output logic [AXIL_ADDR_WIDTH-1:0]   awaddr,
    output logic                         wvalid,
    output logic [AXIL_DATA_WIDTH-1:0]   wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
    output logic                         bready,
    input  logic                         awready,
    input  logic                         wready,
    input  logic                         bvalid,
    input  logic [1:0]                   bresp
`ifdef AXIL_LITE_MASTER_TIMEOUT_EN
    ,
    output logic                         timeout_err
`endif
);
    localparam int STRB_W = AXIL_DATA_WIDTH / 8;

    state_t state, state_next;
    logic   aw_done, w_done, aw_done_next, w_done_next;

    logic [AXIL_ADDR_WIDTH-1:0] addr_q;
    logic [AXIL_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]          wstrb_q;
    logic                       write_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    // AW and W complete independently; the phase ends once both have handshaken.
    always_comb begin
        state_next   = state;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        case (state)
            IDLE: begin
                aw_done_next = 1'b0;
                w_done_next  = 1'b0;
                if (req_valid) begin
                    state_next = req_write ? WR_XFER : RD_ADDR;
                end
            end
            RD_ADDR: if (arready) state_next = RD_DATA;
            RD_DATA: if (rvalid)  state_next = RSP;
            WR_XFER: begin
                aw_done_next = aw_done | awready;
                w_done_next  = w_done | wready;
                if (aw_done_next && w_done_next) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: if (bvalid)    state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are flops loaded from the next state so inputs never reach them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            arvalid   <= (state_next == RD_ADDR);
            rready    <= (state_next == RD_DATA);
            awvalid   <= (state_next == WR_XFER) && !aw_done_next;
            wvalid    <= (state_next == WR_XFER) && !w_done_next;
            bready    <= (state_next == WR_RESP);
            rsp_valid <= (state_next == RSP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                write_q <= req_write;
            end
            if (state == RD_DATA && rvalid) begin
                rsp_write <= write_q;
                rsp_rdata <= rdata;
                rsp_resp  <= rresp;
            end
            if (state == WR_RESP && bvalid) begin
                rsp_write <= write_q;
                rsp_rdata <= '0;
                rsp_resp  <= bresp;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;

`ifdef AXIL_LITE_MASTER_TIMEOUT_EN
    axil_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (state != IDLE && state != RSP),
        .clear      (state_next != state),
        .timeout_err(timeout_err)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule
